// File: rtl/collatz_stats_if.sv
// Result-record interface for collatz_stats.
// master: the monitor (drives the record and res_vld, samples res_rdy).
// slave:  the reporting/IO stage (samples the record, drives res_rdy).
// Signals: res_vld/res_rdy handshake, res_seed, res_steps, res_max, res_sat, res_err,
//          and res_odd when COLLATZ_ODD_CNT_EN is defined.
interface collatz_stats_if #(
    parameter int unsigned XW = 16,
    parameter int unsigned SW = 10
);
    logic          res_vld;
    logic          res_rdy;
    logic [7:0]    res_seed;
    logic [SW-1:0] res_steps;
    logic [XW-1:0] res_max;
    logic          res_sat;
    logic          res_err;
`ifdef COLLATZ_ODD_CNT_EN
    logic [SW-1:0] res_odd;
`endif

    modport master (
        output res_vld,
        input  res_rdy,
        output res_seed,
        output res_steps,
        output res_max,
        output res_sat,
`ifdef COLLATZ_ODD_CNT_EN
        output res_odd,
`endif
        output res_err
    );

    modport slave (
        input  res_vld,
        output res_rdy,
        input  res_seed,
        input  res_steps,
        input  res_max,
        input  res_sat,
`ifdef COLLATZ_ODD_CNT_EN
        input  res_odd,
`endif
        input  res_err
    );
endinterface

// File: rtl/collatz_stats.sv
// collatz_stats: downstream monitor for the Collatz core.
// Per run it latches the seed, counts x changes while bs=1 (saturating), tracks the peak x,
// flags a timeout when bs does not rise within TO cycles of the start, and offers one result
// record over a valid/ready handshake.
// Ports:
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   co, st     seed and start strobe driven to the core
//   x, bs      current value and busy from the core
//   idle       high while waiting for a start
//   res        result record (collatz_stats_if.master)
// Optional feature: define COLLATZ_ODD_CNT_EN to add res_odd, a saturating count of
// counted changes whose previous value was odd (3n+1 steps).
module collatz_stats #(
    parameter int unsigned XW = 16,
    parameter int unsigned SW = 10,
    parameter int unsigned TO = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    co,
    input  logic          st,
    input  logic [XW-1:0] x,
    input  logic          bs,
    output logic          idle,
    collatz_stats_if.master res
);

    localparam int unsigned TW = (TO > 1) ? $clog2(TO) : 1;
    localparam logic [TW-1:0] TmrLast = TW'(TO - 1);
    localparam logic [SW-1:0] CntMax = '1;

    typedef enum logic [1:0] {StIdle, StArm, StRun, StHold} state_e;

    state_e        state_q, state_d;
    logic [7:0]    seed_q, seed_d;
    logic [SW-1:0] steps_q, steps_d;
    logic [XW-1:0] max_q, max_d;
    logic [XW-1:0] x_prev_q, x_prev_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          sat_q, sat_d;
    logic          err_q, err_d;
`ifdef COLLATZ_ODD_CNT_EN
    logic [SW-1:0] odd_q, odd_d;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (st) state_d = StArm;
            StArm: begin
                if (bs) begin
                    state_d = StRun;
                end else if (tmr_q == TmrLast) begin
                    state_d = StHold;
                end
            end
            StRun:  if (!bs) state_d = StHold;
            StHold: if (res.res_rdy) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode the state register only, so no input reaches an output combinationally.
    always_comb begin
        idle        = (state_q == StIdle);
        res.res_vld = (state_q == StHold);
    end

    // Record datapath
    always_comb begin
        seed_d   = seed_q;
        steps_d  = steps_q;
        max_d    = max_q;
        x_prev_d = x_prev_q;
        tmr_d    = tmr_q;
        sat_d    = sat_q;
        err_d    = err_q;
`ifdef COLLATZ_ODD_CNT_EN
        odd_d    = odd_q;
`endif
        case (state_q)
            StIdle: begin
                if (st) begin
                    seed_d  = co;
                    steps_d = '0;
                    max_d   = '0;
                    sat_d   = 1'b0;
                    err_d   = 1'b0;
                    tmr_d   = '0;
`ifdef COLLATZ_ODD_CNT_EN
                    odd_d   = '0;
`endif
                end
            end
            StArm: begin
                if (bs) begin
                    x_prev_d = x;
                    max_d    = x;
                end else if (tmr_q == TmrLast) begin
                    err_d   = 1'b1;
                    steps_d = '0;
                    max_d   = '0;
`ifdef COLLATZ_ODD_CNT_EN
                    odd_d   = '0;
`endif
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StRun: begin
                // A change coinciding with bs falling is deliberately not counted.
                if (bs && (x != x_prev_q)) begin
                    x_prev_d = x;
                    if (x > max_q) max_d = x;
                    if (steps_q != CntMax) begin
                        steps_d = steps_q + 1'b1;
                        if (steps_q == CntMax - 1'b1) sat_d = 1'b1;
                    end
`ifdef COLLATZ_ODD_CNT_EN
                    if (x_prev_q[0] && (odd_q != CntMax)) odd_d = odd_q + 1'b1;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_q   <= '0;
            steps_q  <= '0;
            max_q    <= '0;
            x_prev_q <= '0;
            tmr_q    <= '0;
            sat_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef COLLATZ_ODD_CNT_EN
            odd_q    <= '0;
`endif
        end else begin
            seed_q   <= seed_d;
            steps_q  <= steps_d;
            max_q    <= max_d;
            x_prev_q <= x_prev_d;
            tmr_q    <= tmr_d;
            sat_q    <= sat_d;
            err_q    <= err_d;
`ifdef COLLATZ_ODD_CNT_EN
            odd_q    <= odd_d;
`endif
        end
    end

    assign res.res_seed  = seed_q;
    assign res.res_steps = steps_q;
    assign res.res_max   = max_q;
    assign res.res_sat   = sat_q;
    assign res.res_err   = err_q;
`ifdef COLLATZ_ODD_CNT_EN
    assign res.res_odd   = odd_q;
`endif

endmodule

// File: tb/tb_collatz_stats.sv
// Bench for collatz_stats: a behavioural core drives x/bs, a reference model pushes the
// expected record to a scoreboard at each start, and records are popped when res_vld rises.
// Two instances run side by side: SW=10 and SW=4 (saturation).
module tb_collatz_stats;
    localparam int unsigned XW  = 16;
    localparam int unsigned SW  = 10;
    localparam int unsigned SWS = 4;
    localparam int unsigned TO  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    co  = '0;
    logic          st  = 1'b0;
    logic [XW-1:0] x   = '0;
    logic          bs  = 1'b0;
    logic          rdy = 1'b0;
    logic          idle_a, idle_b;

    int n_checks = 0;
    int n_pass   = 0;

    collatz_stats_if #(.XW(XW), .SW(SW))  res_a ();
    collatz_stats_if #(.XW(XW), .SW(SWS)) res_b ();

    assign res_a.res_rdy = rdy;
    assign res_b.res_rdy = rdy;

    collatz_stats #(.XW(XW), .SW(SW), .TO(TO)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .co   (co),
        .st   (st),
        .x    (x),
        .bs   (bs),
        .idle (idle_a),
        .res  (res_a.master)
    );

    collatz_stats #(.XW(XW), .SW(SWS), .TO(TO)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .co   (co),
        .st   (st),
        .x    (x),
        .bs   (bs),
        .idle (idle_b),
        .res  (res_b.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        int seed;
        int steps;
        int max;
        int sat;
        int err;
        int odd;
        int steps_s;
        int sat_s;
        int odd_s;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    function automatic int collatz_next(input int v);
        return (v % 2 == 1) ? 3 * v + 1 : v / 2;
    endfunction

    function automatic int sat_at(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // Reference: the core presents the seed when bs rises and steps until x reaches 1.
    function automatic exp_t model(input int seed);
        exp_t e;
        int v = seed;
        int raw = 0;
        int odd = 0;
        int lim_a = (1 << SW) - 1;
        int lim_b = (1 << SWS) - 1;
        e.seed = seed;
        e.max  = seed;
        e.err  = 0;
        while (v != 1) begin
            if (v % 2 == 1) odd++;
            v = collatz_next(v);
            raw++;
            if (v > e.max) e.max = v;
        end
        e.steps   = sat_at(raw, lim_a);
        e.sat     = (raw >= lim_a) ? 1 : 0;
        e.odd     = sat_at(odd, lim_a);
        e.steps_s = sat_at(raw, lim_b);
        e.sat_s   = (raw >= lim_b) ? 1 : 0;
        e.odd_s   = sat_at(odd, lim_b);
        return e;
    endfunction

    task automatic do_start(input int seed);
        @(negedge clk);
        co = 8'(seed);
        st = 1'b1;
        sb.push_back(model(seed));
        @(negedge clk);
        st = 1'b0;
    endtask

    // Runs the core from the current negedge; ends at the negedge where res_vld should be up.
    task automatic drive_core(input int seed);
        int n = 0;
        bs = 1'b1;
        x  = XW'(seed);
        while (x != 1 && n < 500) begin
            @(negedge clk);
            x = XW'(collatz_next(int'(x)));
            n++;
        end
        @(negedge clk);
        check("vld_before_end", 32'(res_a.res_vld), 0);
        bs = 1'b0;
        @(negedge clk);
        check("vld_latency", 32'(res_a.res_vld), 1);
    endtask

    task automatic check_record();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        check("seed",    32'(res_a.res_seed),  e.seed);
        check("steps",   32'(res_a.res_steps), e.steps);
        check("max",     32'(res_a.res_max),   e.max);
        check("sat",     32'(res_a.res_sat),   e.sat);
        check("err",     32'(res_a.res_err),   e.err);
        check("b_vld",   32'(res_b.res_vld),   1);
        check("b_steps", 32'(res_b.res_steps), e.steps_s);
        check("b_max",   32'(res_b.res_max),   e.max);
        check("b_sat",   32'(res_b.res_sat),   e.sat_s);
        check("b_err",   32'(res_b.res_err),   e.err);
`ifdef COLLATZ_ODD_CNT_EN
        check("odd",     32'(res_a.res_odd),   e.odd);
        check("b_odd",   32'(res_b.res_odd),   e.odd_s);
`endif
    endtask

    task automatic handshake();
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        check("idle_after_xfer", 32'(idle_a), 1);
        check("vld_after_xfer",  32'(res_a.res_vld), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_vld",   32'(res_a.res_vld),   0);
        check("rst_seed",  32'(res_a.res_seed),  0);
        check("rst_steps", 32'(res_a.res_steps), 0);
        check("rst_max",   32'(res_a.res_max),   0);
        check("rst_sat",   32'(res_a.res_sat),   0);
        check("rst_err",   32'(res_a.res_err),   0);
        check("rst_idle",  32'(idle_a),          1);
        check("rst_idle_b", 32'(idle_b),         1);
`ifdef COLLATZ_ODD_CNT_EN
        check("rst_odd",   32'(res_a.res_odd),   0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int cycles;
        exp_t e;

        #1 rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;

        // Seed 6
        do_start(6);
        drive_core(6);
        check_record();
        handshake();
        check("hold_after_xfer", 32'(res_a.res_steps), 8);

        // Seed 27, also saturates the SW=4 instance
        do_start(27);
        drive_core(27);
        check_record();
        handshake();

        // Timeout: bs never rises
        @(negedge clk);
        co = 8'd5;
        st = 1'b1;
        e = '{seed: 5, steps: 0, max: 0, sat: 0, err: 1, odd: 0, steps_s: 0, sat_s: 0, odd_s: 0};
        sb.push_back(e);
        @(negedge clk);
        st = 1'b0;
        cycles = 0;
        while (res_a.res_vld !== 1'b1 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        check("timeout_latency", 32'(cycles), TO);
        check_record();
        handshake();

        // Stalled consumer with st pulses in HOLD
        do_start(6);
        drive_core(6);
        for (int i = 0; i < 20; i++) begin
            co = 8'd99;
            st = (i % 2 == 0);
            @(negedge clk);
            check("stall_vld",  32'(res_a.res_vld),  1);
            check("stall_seed", 32'(res_a.res_seed), 6);
        end
        st = 1'b0;
        check_record();
        // st during the handshake cycle is lost
        st = 1'b1;
        handshake();
        st = 1'b0;
        @(negedge clk);
        check("st_lost_idle", 32'(idle_a), 1);
        do_start(7);
        drive_core(7);
        check_record();
        handshake();

        // Reset in the middle of a run
        do_start(27);
        bs = 1'b1;
        x  = 16'd27;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            x = XW'(collatz_next(int'(x)));
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        void'(sb.pop_back());
        bs = 1'b0;
        x  = '0;
        @(negedge clk);
        rst = 1'b0;
        do_start(6);
        drive_core(6);
        check_record();
        handshake();

        check("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
